pal_frame_tracker: RTL

//  Receive-side counterpart to the frame-start flag generator: consumes the one-clock frame_start pulse

---
 rtl/pal_timing_pkg.sv | 22 ++
 rtl/pal_frame_tracker_if.sv | 40 ++++
 rtl/pal_xy_counter.sv | 58 +++++
 rtl/pal_frame_tracker.sv | 119 +++++++++++
 4 files changed

// File: rtl/pal_timing_pkg.sv
// Shared timing definitions for the PAL frame tracker: default raster size,
// coordinate width, tracker state encoding and a small wrap helper.
package pal_timing_pkg;

   localparam int H_PIXELS_DEF = 768;
   localparam int V_LINES_DEF  = 576;
   localparam int COORD_W      = 10;

   typedef logic [COORD_W-1:0] coord_t;

   typedef enum logic [1:0] {
      ST_SEARCH = 2'd0,
      ST_VERIFY = 2'd1,
      ST_LOCKED = 2'd2
   } trk_state_t;

   // True when v is the last position of a dimension holding n positions.
   function automatic logic is_last(input coord_t v, input int n);
      return v == coord_t'(n - 1);
   endfunction

endpackage

// File: rtl/pal_frame_tracker_if.sv
// Bus between a frame-start source and the PAL frame tracker.
// Optional: PAL_TRACKER_ERRCNT_EN adds the err_count field.
//
// Signalling: pixel_ce is a strobe; every high clock consumes exactly one
// pixel position and there is no backpressure. frame_start is a one-clock
// pulse on the clock after the pixel_ce that consumed (0,0). Tracker outputs
// are registered; frame_done and sync_error are one-clock pulses, trk_valid
// is a level, and state mirrors the tracker FSM for observation.
interface pal_frame_tracker_if;
   import pal_timing_pkg::*;

   logic       pixel_ce;
   logic       frame_start;
   coord_t     trk_x;
   coord_t     trk_y;
   logic       trk_valid;
   logic       frame_done;
   logic       sync_error;
   trk_state_t state;
`ifdef PAL_TRACKER_ERRCNT_EN
   logic [7:0] err_count;
`endif

   modport master (
      output pixel_ce, frame_start,
      input  trk_x, trk_y, trk_valid, frame_done, sync_error, state
`ifdef PAL_TRACKER_ERRCNT_EN
      , input err_count
`endif
   );

   modport slave (
      input  pixel_ce, frame_start,
      output trk_x, trk_y, trk_valid, frame_done, sync_error, state
`ifdef PAL_TRACKER_ERRCNT_EN
      , output err_count
`endif
   );

endinterface

// File: rtl/pal_xy_counter.sv
// Wrapping raster position counter. x/y always hold the position the next
// increment consumes. load forces (1,0); when load and inc coincide the load
// is applied first and the increment then advances from (1,0).
module pal_xy_counter
   import pal_timing_pkg::*;
#(
   parameter int H_PIXELS = H_PIXELS_DEF,
   parameter int V_LINES  = V_LINES_DEF
) (
   input  logic   clk,
   input  logic   reset_n,
   input  logic   load,
   input  logic   inc,
   output coord_t x,
   output coord_t y,
   output logic   at_origin
);

   coord_t x_q, y_q;
   coord_t x_base, y_base;
   coord_t x_n, y_n;

   // Next position: optional load to (1,0), then optional wrapping increment.
   always_comb begin
      x_base = load ? coord_t'(1) : x_q;
      y_base = load ? '0 : y_q;
      x_n    = x_base;
      y_n    = y_base;
      if (inc) begin
         if (is_last(x_base, H_PIXELS)) begin
            x_n = '0;
            if (is_last(y_base, V_LINES)) begin
               y_n = '0;
            end else begin
               y_n = y_base + coord_t'(1);
            end
         end else begin
            x_n = x_base + coord_t'(1);
         end
      end
   end

   // Position register.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         x_q <= '0;
         y_q <= '0;
      end else begin
         x_q <= x_n;
         y_q <= y_n;
      end
   end

   assign x         = x_q;
   assign y         = y_q;
   assign at_origin = (x_q == '0) && (y_q == '0);

endmodule

// File: rtl/pal_frame_tracker.sv
// PAL frame tracker: rebuilds the raster position from pixel_ce and the
// frame_start pulse, checks frame length and supervises lock with a
// SEARCH/VERIFY/LOCKED FSM.
// Optional: PAL_TRACKER_ERRCNT_EN adds a saturating 8-bit sync_error counter.
module pal_frame_tracker
   import pal_timing_pkg::*;
#(
   parameter int H_PIXELS = H_PIXELS_DEF,
   parameter int V_LINES  = V_LINES_DEF
) (
   input  logic                clk,
   input  logic                reset_n,
   pal_frame_tracker_if.slave  bus
);

   coord_t     cnt_x, cnt_y;
   logic       at_origin;
   logic       exp_fs_q;
   trk_state_t state_q, state_n;
   logic       done_n, err_n;
   logic       valid_q, done_q, err_q;

   // Every frame_start re-anchors the counter; when in sync this is a no-op.
   pal_xy_counter #(
      .H_PIXELS (H_PIXELS),
      .V_LINES  (V_LINES)
   ) u_xy (
      .clk       (clk),
      .reset_n   (reset_n),
      .load      (bus.frame_start),
      .inc       (bus.pixel_ce),
      .x         (cnt_x),
      .y         (cnt_y),
      .at_origin (at_origin)
   );

   // Expect frame_start on the clock after a pixel_ce consumed (0,0); a
   // coincident frame_start means (1,0) was consumed instead.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         exp_fs_q <= 1'b0;
      end else begin
         exp_fs_q <= bus.pixel_ce && !bus.frame_start && at_origin;
      end
   end

   // Lock supervision: next state and pulse requests.
   always_comb begin
      state_n = state_q;
      done_n  = 1'b0;
      err_n   = 1'b0;
      unique case (state_q)
         ST_SEARCH: begin
            if (bus.frame_start) state_n = ST_VERIFY;
         end
         ST_VERIFY: begin
            if (bus.frame_start && exp_fs_q) begin
               state_n = ST_LOCKED;
               done_n  = 1'b1;
            end else if (bus.frame_start) begin
               err_n   = 1'b1;
            end else if (exp_fs_q) begin
               err_n   = 1'b1;
               state_n = ST_SEARCH;
            end
         end
         ST_LOCKED: begin
            if (bus.frame_start && exp_fs_q) begin
               done_n  = 1'b1;
            end else if (bus.frame_start) begin
               err_n   = 1'b1;
               state_n = ST_VERIFY;
            end else if (exp_fs_q) begin
               err_n   = 1'b1;
               state_n = ST_SEARCH;
            end
         end
         default: state_n = ST_SEARCH;
      endcase
   end

   // State and registered status outputs; trk_valid is taken from next state.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q <= ST_SEARCH;
         valid_q <= 1'b0;
         done_q  <= 1'b0;
         err_q   <= 1'b0;
      end else begin
         state_q <= state_n;
         valid_q <= (state_n == ST_LOCKED);
         done_q  <= done_n;
         err_q   <= err_n;
      end
   end

`ifdef PAL_TRACKER_ERRCNT_EN
   logic [7:0] err_cnt_q;

   // Saturating count of sync_error pulses; cleared only by reset_n.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         err_cnt_q <= '0;
      end else if (err_n && (err_cnt_q != 8'hFF)) begin
         err_cnt_q <= err_cnt_q + 8'd1;
      end
   end

   assign bus.err_count = err_cnt_q;
`endif

   assign bus.trk_x      = cnt_x;
   assign bus.trk_y      = cnt_y;
   assign bus.trk_valid  = valid_q;
   assign bus.frame_done = done_q;
   assign bus.sync_error = err_q;
   assign bus.state      = state_q;

endmodule
